// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encodings and the access-legality rule.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // Misaligned halfword/word, reserved codes, and unsigned-width stores are illegal.
  function automatic logic access_error(input logic is_store, input logic [2:0] funct3,
                                        input logic [1:0] offset);
    case (funct3)
      F3_B:    access_error = 1'b0;
      F3_H:    access_error = offset[0];
      F3_W:    access_error = (offset != 2'b00);
      F3_BU:   access_error = is_store;
      F3_HU:   access_error = is_store | offset[0];
      default: access_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{byte_off, 3'b000} +: 8];
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'd0, sel_half};
      default: load_data = rdata;
    endcase
  end

  // Untouched lanes keep the values just read back from memory.
  always_comb begin
    merged_word = rdata;
    if (funct3 == F3_B)
      merged_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H)
      merged_word[{byte_off[1], 4'b0000} +: 16] = wdata;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for RV32I data accesses, driving a
// 1-cycle-latency word memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_defs::*;
#(
  parameter int RAM_ADDR_BITS = 9,
  parameter int RAM_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_error,
  output logic                     mem_enable,
  output logic                     mem_write_enable,
  output logic [RAM_ADDR_BITS-1:0] mem_address,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata
);

  logic [2:0]               state;
  logic                     write_q;
  logic [2:0]               funct3_q;
  logic [RAM_ADDR_BITS+1:0] addr_q;
  logic [15:0]              wdata_q;
  logic [RAM_WIDTH-1:0]     word_q;
  logic [31:0]              load_data;
  logic [31:0]              merged_word;
  logic                     unused_addr_bits;

  // Address bits above the memory range are dropped, so accesses wrap.
  assign unused_addr_bits = ^req_addr[31:RAM_ADDR_BITS+2];

  assign req_ready        = (state == S_IDLE);
  assign resp_valid       = (state == S_RESP);
  assign mem_enable       = (state == S_RD) || (state == S_WR);
  assign mem_write_enable = (state == S_WR);
  assign mem_address      = addr_q[RAM_ADDR_BITS+1:2];
  assign mem_wdata        = word_q;

  lsu_lane_align u_lane_align (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merged_word(merged_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      write_q    <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 16'd0;
      word_q     <= '0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[RAM_ADDR_BITS+1:0];
            wdata_q  <= req_wdata[15:0];
            if (access_error(req_write, req_funct3, req_addr[1:0])) begin
              resp_rdata <= 32'd0;
              resp_error <= 1'b1;
              state      <= S_RESP;
            end else if (req_write && req_funct3 == F3_W) begin
              word_q <= req_wdata;
              state  <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: state <= S_RD_DATA;
        S_RD_DATA: begin
          if (write_q) begin
            word_q <= merged_word;
            state  <= S_WR;
          end else begin
            resp_rdata <= load_data;
            resp_error <= 1'b0;
            state      <= S_RESP;
          end
        end
        S_WR: begin
          resp_rdata <= 32'd0;
          resp_error <= 1'b0;
          state      <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural memory model predicts
// every response; a separate monitor compares them as the unit completes.
module tb_load_store_unit;

  localparam int AW = 9;
  localparam int NWORDS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic          mem_enable;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tb_ram[NWORDS];
  logic [31:0] ref_mem[NWORDS];
  logic        preloaded = 1'b0;
  int          cyc = 0;
  int          write_count = 0;
  int          en_count = 0;
  logic [AW-1:0] last_rd_addr = '0;
  int          resp_seen = 0;
  int          exp_writes = 0;
  int          next_id = 0;
  int          errors = 0;
  int          checks = 0;

  load_store_unit #(.RAM_ADDR_BITS(AW), .RAM_WIDTH(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .mem_enable      (mem_enable),
    .mem_write_enable(mem_write_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) init_word = 32'h8899AABB;
    else        init_word = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Attached data memory with one cycle of read latency.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!preloaded) begin
      for (int i = 0; i < NWORDS; i++) tb_ram[i] <= init_word(i);
      preloaded <= 1'b1;
    end else if (mem_enable) begin
      en_count <= en_count + 1;
      if (mem_write_enable) begin
        tb_ram[mem_address] <= mem_wdata;
        write_count <= write_count + 1;
      end else begin
        mem_rdata    <= tb_ram[mem_address];
        last_rd_addr <= mem_address;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  // Reference: word-array memory with byte arithmetic on the architectural rules.
  task automatic refAccess(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic er,
                           output int lat);
    int unsigned idx, off, sh, hsh;
    logic [31:0] w, byte_v, half_v;
    idx = (a / 4) % NWORDS;
    off = a % 4;
    sh  = 8 * off;
    hsh = 16 * (off / 2);
    er = 1'b0;
    if (f3 == 3 || f3 == 6 || f3 == 7) er = 1'b1;
    if (wr && (f3 == 4 || f3 == 5)) er = 1'b1;
    if ((f3 == 1 || f3 == 5) && (off % 2 == 1)) er = 1'b1;
    if (f3 == 2 && off != 0) er = 1'b1;
    rd = 32'd0;
    if (er) begin
      lat = 1;
      return;
    end
    w      = ref_mem[idx];
    byte_v = (w >> sh) & 32'hFF;
    half_v = (w >> hsh) & 32'hFFFF;
    if (!wr) begin
      lat = 3;
      case (f3)
        3'd0:    rd = (byte_v > 127) ? byte_v - 32'd256 : byte_v;
        3'd1:    rd = (half_v > 32767) ? half_v - 32'd65536 : half_v;
        3'd4:    rd = byte_v;
        3'd5:    rd = half_v;
        default: rd = w;
      endcase
    end else begin
      exp_writes++;
      if (f3 == 2) begin
        lat = 2;
        ref_mem[idx] = d;
      end else if (f3 == 0) begin
        lat = 4;
        ref_mem[idx] = w - (byte_v << sh) + ((d % 256) << sh);
      end else begin
        lat = 4;
        ref_mem[idx] = w - (half_v << hsh) + ((d % 65536) << hsh);
      end
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input logic fixed,
                               input logic [31:0] fx_rdata, input logic fx_err);
    int n;
    exp_t e;
    logic [31:0] mr;
    logic me;
    int lat;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_ready_timeout: got 0, wanted 1 within 40 cycles");
      return;
    end
    refAccess(wr, f3, a, d, mr, me, lat);
    e.rdata = fixed ? fx_rdata : mr;
    e.err   = fixed ? fx_err : me;
    e.due   = cyc + lat;
    e.id    = next_id;
    next_id++;
    exp_q.push_back(e);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0 || !req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: pending=%0d ready=%0b, wanted 0 and 1", exp_q.size(), req_ready);
    end
  endtask

  task automatic resetMidRmw();
    int wr_before, resp_before;
    @(negedge clock);
    wr_before   = write_count;
    resp_before = resp_seen;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h10;
    req_wdata  = 32'h1234;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    // Now in RD_DATA; a load presented alongside reset must be ignored.
    #1;
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (6) @(negedge clock);
    checkOutput("rst_mid_writes", write_count, wr_before);
    checkOutput("rst_mid_responses", resp_seen, resp_before);
    checkOutput("rst_mid_word4", tb_ram[4], 32'h889955BB);
  endtask

  // Monitor: compares every response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && resp_valid) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1, wanted none pending");
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("resp%0d_rdata", e.id), resp_rdata, e.rdata);
          checkOutput($sformatf("resp%0d_error", e.id), {31'd0, resp_error}, {31'd0, e.err});
          checkOutput($sformatf("resp%0d_cycle", e.id), cyc, e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en_before;
    int bad;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_error", {31'd0, resp_error}, 32'd0);
    checkOutput("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("rst_mem_address", {23'd0, mem_address}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);

    $display("[TB] directed loads and sub-word store");
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h8899AABB, 1'b0);
    applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFF88, 1'b0);
    applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h00000088, 1'b0);
    applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFF8899, 1'b0);
    applyStimulus(1'b1, 3'b000, 32'h11, 32'h55, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h889955BB, 1'b0);
    waitDrain();
    checkOutput("sb_word4", tb_ram[4], 32'h889955BB);

    $display("[TB] misaligned accesses");
    en_before = en_count;
    applyStimulus(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'b001, 32'h13, 32'hBEEF, 1'b1, 32'h0, 1'b1);
    waitDrain();
    checkOutput("misaligned_mem_enables", en_count, en_before);

    $display("[TB] address wrap");
    applyStimulus(1'b0, 3'b010, 32'h00000800, 32'h0, 1'b1, init_word(0), 1'b0);
    waitDrain();
    checkOutput("wrap_mem_address", {23'd0, last_rd_addr}, 32'd0);

    $display("[TB] reset during read-modify-write");
    resetMidRmw();

    $display("[TB] randomized accesses");
    for (int k = 0; k < 80; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 1)), f3, a, $urandom, 1'b0, 32'h0, 1'b0);
    end
    waitDrain();

    checkOutput("total_writes", write_count, exp_writes);
    bad = 0;
    for (int i = 0; i < NWORDS; i++) if (tb_ram[i] !== ref_mem[i]) bad++;
    checkOutput("mem_words_differing", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RAM_ADDR_BITS, default 9, giving the word-address width of the attached data memory.
REQ-002 SHALL have parameter RAM_WIDTH, default 32, giving the memory word width; only 32 is supported.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a core access request.
REQ-006 SHALL have port req_ready, output, 1, high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-007 SHALL have port req_write, input, 1, where 1 means store and 0 means load.
REQ-008 SHALL have port req_funct3, input, 3, the RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr, input, 32, the byte address.
REQ-010 SHALL have port req_wdata, input, 32, the store data (right-aligned).
REQ-011 SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 32, the extended load data; 0 for stores and errors; held until the next response.
REQ-013 SHALL have port resp_error, output, 1, flagging misaligned or illegal access; valid with resp_valid.
REQ-014 SHALL have the memory ports: mem_enable out 1; mem_write_enable out 1; mem_address out RAM_ADDR_BITS; mem_wdata out 32; mem_rdata in 32 (valid one cycle after a read enable).

Function
REQ-015 SHALL capture req_write, req_funct3, req_addr and req_wdata on acceptance and ignore the request inputs until the next IDLE.
REQ-016 SHALL drive mem_address = captured addr[RAM_ADDR_BITS+1:2], ignoring higher address bits (wrap-around).
REQ-017 SHALL implement states IDLE, RD, RD_DATA, WR and RESP.
REQ-018 SHALL transition from IDLE on acceptance as follows: error -> RESP; SW -> WR; load, SB or SH -> RD.
REQ-019 SHALL, in RD, assert mem_enable=1 and mem_write_enable=0, then go to RD_DATA.
REQ-020 SHALL, in RD_DATA, sample mem_rdata; a load registers the extracted data and goes to RESP; SB/SH merges the data into a word register and goes to WR.
REQ-021 SHALL, in WR, assert mem_enable=1 and mem_write_enable=1 with mem_wdata = the store word (SW) or the merged word (SB/SH), then go to RESP.
REQ-022 SHALL, in RESP, assert resp_valid for one cycle and return to IDLE; mem_enable SHALL be 0 in IDLE, RD_DATA and RESP.
REQ-023 SHALL use these latencies from the acceptance cycle (cycle 0) to resp_valid: load 3; SW 2; SB/SH 4; error 1.
REQ-024 SHALL use little-endian byte lanes, lane n = bits [8n+7:8n], selected by addr[1:0]; the halfword lane is addr[1].
REQ-025 SHALL extract load data as follows: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-026 SHALL merge store data with SB replacing only lane addr[1:0] with wdata[7:0] and SH replacing only the halfword with wdata[15:0]; other bytes SHALL keep their read values.
REQ-027 SHALL treat as errors: H/HU with addr[0]=1; W with addr[1:0]!=00; funct3 011, 110 or 111; a store with funct3 100 or 101.
REQ-028 SHALL make no memory access on error and SHALL return resp_error=1 with resp_rdata=0.
REQ-029 SHALL keep only one access outstanding, with req_ready=0 from RD through RESP.

Reset
REQ-030 SHALL, when reset is high, force state IDLE, resp_valid=0, resp_rdata=0, resp_error=0, mem_enable=0, mem_write_enable=0, mem_address=0, mem_wdata=0 and req_ready=1 in the following cycle.
REQ-031 SHALL handle reset mid-operation by abandoning the access with no response; a pending RMW write SHALL NOT be issued.
REQ-032 SHALL ignore a request presented during the reset cycle.

Structure
REQ-033 SHALL place the funct3 width codes and the state encodings in a shared package, lsu_defs.
REQ-034 SHALL implement lane extract/merge in one combinational sub-module, lsu_lane_align, instantiated once.
REQ-035 SHALL have no memory array; the unit connects directly to the data memory with 1-cycle read latency.

Verification
REQ-036 SHALL verify LW: word 0x04 = 0x8899AABB, LW addr 0x10 -> resp_valid at cycle 3, resp_rdata=0x8899AABB, resp_error=0.
REQ-037 SHALL verify LB/LBU: same word, LB addr 0x13 -> 0xFFFFFF88; LBU addr 0x13 -> 0x00000088; LH addr 0x12 -> 0xFFFF8899.
REQ-038 SHALL verify SB RMW: word 0x04 = 0x8899AABB, SB addr 0x11 data 0x55 -> one write of 0x889955BB, resp at cycle 4; a following LW -> 0x889955BB.
REQ-039 SHALL verify misaligned: LW addr 0x12 and SH addr 0x13 -> resp_error=1 at cycle 1, resp_rdata=0, mem_enable never asserted.
REQ-040 SHALL verify reset mid-RMW: SH addr 0x10, reset in RD_DATA -> no write, no resp_valid, req_ready=1 the next cycle, word unchanged.
REQ-041 SHALL verify wrap: LW addr 0x00000800 with RAM_ADDR_BITS=9 -> mem_address=0.
